// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator: waveform encodings, parameter
// legality limits and the quarter-wave sine amplitude used to fill the ROM.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  localparam int ACC_W_MAX        = 64;
  localparam int OUT_W_MIN        = 2;
  // Truncated phase must carry at least one bit beyond the output width.
  localparam int PHASE_OUT_MARGIN = 1;

  function automatic bit params_legal(int acc_w, int phase_w, int out_w);
    return (out_w >= OUT_W_MIN) &&
           (phase_w >= out_w + PHASE_OUT_MARGIN) &&
           (phase_w <= acc_w) &&
           (acc_w <= ACC_W_MAX);
  endfunction

  // Half-bin offset keeps the quarter table symmetric about the quadrant edges.
  function automatic int quarter_sine_amp(int idx, int phase_w, int out_w);
    real ang;
    real peak;
    ang  = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(2 ** (phase_w - 2));
    peak = real'((2 ** (out_w - 1)) - 1);
    return $rtoi(peak * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_if.sv
// Control and sample-stream signals of the DDS generator. The master side
// drives configuration and enables; the slave side is the generator itself.
interface dds_if #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 10
);
  logic               en;
  logic               cfg_load;
  logic [ACC_W-1:0]   fword_in;
  logic [PHASE_W-1:0] pword_in;
  logic [1:0]         wave_sel_in;
  logic               sync_clr;
  logic [OUT_W-1:0]   dout;
  logic               dout_valid;
  logic               wrap;

  modport master (
    output en, cfg_load, fword_in, pword_in, wave_sel_in, sync_clr,
    input  dout, dout_valid, wrap
  );

  modport slave (
    input  en, cfg_load, fword_in, pword_in, wave_sel_in, sync_clr,
    output dout, dout_valid, wrap
  );
endinterface

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine ROM with a registered read port; contents are computed
// at elaboration from the half-bin-centred sine amplitude.
module dds_quarter_lut
  import dds_pkg::*;
#(
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 10
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [PHASE_W-3:0] addr,
  output logic [OUT_W-2:0]   data
);

  localparam int DEPTH = 2 ** (PHASE_W - 2);

  logic [OUT_W-2:0] rom [DEPTH];
  logic [OUT_W-2:0] data_q;
  logic [OUT_W-2:0] data_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = (OUT_W-1)'(quarter_sine_amp(gi, PHASE_W, OUT_W));
  end

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = rom[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/dds_gen.sv
// Direct digital synthesiser: phase accumulator followed by a three-stage
// pipeline (phase add, quarter-wave ROM read, waveform select/format).
module dds_gen
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 10
) (
  input  logic clk,
  input  logic rst_n,
  dds_if.slave bus
);

  if (!params_legal(ACC_W, PHASE_W, OUT_W)) begin : g_bad_params
    $error("dds_gen: illegal ACC_W/PHASE_W/OUT_W combination");
  end

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Shadow configuration and accumulator
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   fword_q, fword_d;
  logic [PHASE_W-1:0] pword_q, pword_d;
  wave_e              wsel_q, wsel_d;
  logic               v0_q, v0_d;
  logic               wrap0_q, wrap0_d;
  logic [ACC_W:0]     sum;

  // Stage 1: phase
  logic               v1_q, v1_d;
  logic               wrap1_q, wrap1_d;
  logic [PHASE_W-1:0] ph1_q, ph1_d;
  wave_e              wsel1_q, wsel1_d;
  logic [PHASE_W-3:0] lut_addr;

  // Stage 2: ROM read; only the phase bits the formatters need travel on
  logic               v2_q, v2_d;
  logic               wrap2_q, wrap2_d;
  logic [OUT_W:0]     ph2_q, ph2_d;
  wave_e              wsel2_q, wsel2_d;
  logic [OUT_W-2:0]   lut_data;

  // Stage 3: output
  logic [OUT_W-1:0]   sample;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               wrap_q, wrap_d;

  dds_quarter_lut #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_lut (
    .clk   (clk),
    .rd_en (v1_q),
    .addr  (lut_addr),
    .data  (lut_data)
  );

  always_comb begin
    fword_d = fword_q;
    pword_d = pword_q;
    wsel_d  = wsel_q;
    if (bus.cfg_load) begin
      fword_d = bus.fword_in;
      pword_d = bus.pword_in;
      wsel_d  = wave_e'(bus.wave_sel_in);
    end

    sum     = {1'b0, acc_q} + {1'b0, fword_q};
    acc_d   = acc_q;
    wrap0_d = 1'b0;
    v0_d    = bus.en;
    if (bus.sync_clr) begin
      acc_d = '0;
    end else if (bus.en) begin
      acc_d   = sum[ACC_W-1:0];
      wrap0_d = sum[ACC_W];
    end

    v1_d    = v0_q;
    wrap1_d = wrap0_q;
    ph1_d   = ph1_q;
    wsel1_d = wsel1_q;
    if (v0_q) begin
      ph1_d   = acc_q[ACC_W-1 -: PHASE_W] + pword_q;
      wsel1_d = wsel_q;
    end

    // Quadrants 1 and 3 run the quarter table backwards.
    lut_addr = ph1_q[PHASE_W-3:0];
    if (ph1_q[PHASE_W-2]) lut_addr = ~ph1_q[PHASE_W-3:0];

    v2_d    = v1_q;
    wrap2_d = wrap1_q;
    ph2_d   = ph2_q;
    wsel2_d = wsel2_q;
    if (v1_q) begin
      ph2_d   = ph1_q[PHASE_W-1 -: OUT_W+1];
      wsel2_d = wsel1_q;
    end

    unique case (wsel2_q)
      WAVE_SINE:     sample = ph2_q[OUT_W] ? MID - {1'b0, lut_data} : MID + {1'b0, lut_data};
      WAVE_SQUARE:   sample = ph2_q[OUT_W] ? '0 : '1;
      WAVE_TRIANGLE: sample = ph2_q[OUT_W] ? ~ph2_q[OUT_W-1:0] : ph2_q[OUT_W-1:0];
      default:       sample = ph2_q[OUT_W -: OUT_W];
    endcase

    dout_d       = v2_q ? sample : dout_q;
    dout_valid_d = v2_q;
    wrap_d       = v2_q & wrap2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      fword_q      <= '0;
      pword_q      <= '0;
      wsel_q       <= WAVE_SINE;
      v0_q         <= 1'b0;
      wrap0_q      <= 1'b0;
      v1_q         <= 1'b0;
      wrap1_q      <= 1'b0;
      ph1_q        <= '0;
      wsel1_q      <= WAVE_SINE;
      v2_q         <= 1'b0;
      wrap2_q      <= 1'b0;
      ph2_q        <= '0;
      wsel2_q      <= WAVE_SINE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fword_q      <= fword_d;
      pword_q      <= pword_d;
      wsel_q       <= wsel_d;
      v0_q         <= v0_d;
      wrap0_q      <= wrap0_d;
      v1_q         <= v1_d;
      wrap1_q      <= wrap1_d;
      ph1_q        <= ph1_d;
      wsel1_q      <= wsel1_d;
      v2_q         <= v2_d;
      wrap2_q      <= wrap2_d;
      ph2_q        <= ph2_d;
      wsel2_q      <= wsel2_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_dds_gen.sv
// Scoreboard bench for dds_gen: the driver predicts each sample and pushes it
// into a queue; a negedge monitor pops and compares whenever dout_valid is high.
module tb_dds_gen;

  localparam int ACC_W   = 32;
  localparam int PHASE_W = 12;
  localparam int OUT_W   = 10;
  localparam real PI     = 3.14159265358979323846;

  logic clk;
  logic rst_n;

  dds_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  dds_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int dout;
    bit wrap;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   drv_edge  = 0;
  int   mon_edge  = 0;
  int   wrap_seen = 0;

  // Reference state
  logic [31:0] m_acc;
  logic [31:0] m_fword;
  int          m_pword;
  int          m_ws;
  int          m_last;
  bit          pend_v;
  bit          pend_wrap;
  int          pend_top;
  int          pend_edge;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mon_edge <= mon_edge + 1;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, mon_edge);
    end
  endfunction

  function automatic int exp_sample(int ph, int ws);
    int q;
    int idx;
    int a;
    int t;
    case (ws)
      0: begin
        q   = ph / 1024;
        idx = ph % 1024;
        if (q == 1 || q == 3) idx = 1023 - idx;
        a = $rtoi(511.0 * $sin(PI / 2.0 * (real'(idx) + 0.5) / 1024.0) + 0.5);
        return (q < 2) ? 512 + a : 512 - a;
      end
      1: return (ph < 2048) ? 1023 : 0;
      2: begin
        t = (ph / 2) % 1024;
        return (ph < 2048) ? t : 1023 - t;
      end
      default: return ph / 4;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wrap) wrap_seen++;
      if (bus.dout_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("sample edge=%0d dout=%0d wrap=%0d exp_dout=%0d exp_wrap=%0d",
                   mon_edge, bus.dout, bus.wrap, e.dout, e.wrap);
          check("dout", int'(bus.dout), e.dout);
          check("wrap", int'(bus.wrap), int'(e.wrap));
          check("latency_edge", mon_edge, e.due);
        end
      end else begin
        check("wrap_without_valid", int'(bus.wrap), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    drv_edge++;
  endtask

  // One clock of stimulus; the model mirrors the edge it just crossed.
  task automatic step(bit en, bit clr, bit ld, logic [31:0] fw, int pw, int ws);
    logic [32:0] sum;
    logic [11:0] pw12;
    bit          nwrap;
    exp_t        e;
    pw12            = pw[11:0];
    bus.en          = en;
    bus.sync_clr    = clr;
    bus.cfg_load    = ld;
    bus.fword_in    = fw;
    bus.pword_in    = pw12;
    bus.wave_sel_in = 2'(ws);
    tick();
    if (pend_v) begin
      m_last = exp_sample((pend_top + m_pword) % 4096, m_ws);
      e.dout = m_last;
      e.wrap = pend_wrap;
      e.due  = pend_edge + 3;
      sb_q.push_back(e);
    end
    pend_v = 1'b0;
    nwrap  = 1'b0;
    if (clr) begin
      m_acc = '0;
    end else if (en) begin
      sum   = {1'b0, m_acc} + {1'b0, m_fword};
      m_acc = sum[31:0];
      nwrap = sum[32];
    end
    if (en) begin
      pend_v    = 1'b1;
      pend_top  = int'(m_acc[31:20]);
      pend_wrap = nwrap;
      pend_edge = drv_edge;
    end
    if (ld) begin
      m_fword = fw;
      m_pword = int'(pw12);
      m_ws    = ws;
    end
    bus.cfg_load = 1'b0;
    bus.sync_clr = 1'b0;
  endtask

  task automatic mid_reset();
    #2;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    check("rst_dout", int'(bus.dout), 0);
    check("rst_dout_valid", int'(bus.dout_valid), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    check("rst_acc", int'(dut.acc_q != '0), 0);
    m_acc   = '0;
    m_fword = '0;
    m_pword = 0;
    m_ws    = 0;
    m_last  = 0;
    pend_v  = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int wrap_base;
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.sync_clr    = 1'b0;
    bus.fword_in    = '0;
    bus.pword_in    = '0;
    bus.wave_sel_in = '0;
    m_acc   = '0;
    m_fword = '0;
    m_pword = 0;
    m_ws    = 0;
    m_last  = 0;
    pend_v  = 1'b0;
    tick();
    tick();
    check("init_dout", int'(bus.dout), 0);
    check("init_dout_valid", int'(bus.dout_valid), 0);
    check("init_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;
    tick();

    // Sawtooth at 2^20: one output step per four samples, one wrap per 4096
    step(0, 0, 1, 32'h0010_0000, 0, 3);
    wrap_base = wrap_seen;
    repeat (4100) step(1, 0, 0, '0, 0, 0);
    repeat (4) step(0, 0, 0, '0, 0, 0);
    check("saw_wrap_count", wrap_seen - wrap_base, 1);

    // Square at 2^31 after a phase clear: alternating full-scale / zero
    step(1, 1, 1, 32'h8000_0000, 0, 1);
    repeat (8) step(1, 0, 0, '0, 0, 0);
    repeat (4) step(0, 0, 0, '0, 0, 0);

    // Frozen accumulator: sine at the pword phase only
    step(0, 1, 1, '0, 1024, 0);
    repeat (6) step(1, 0, 0, '0, 0, 0);
    check("sine_pw1024", int'(bus.dout), 1023);
    step(1, 0, 1, '0, 3072, 0);
    repeat (6) step(1, 0, 0, '0, 0, 0);
    check("sine_pw3072", int'(bus.dout), 1);

    // Enable gap holds dout; sync_clr realigns to phase zero
    step(1, 0, 1, 32'h0040_0000, 0, 0);
    repeat (10) step(1, 0, 0, '0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, '0, 0, 0);
      if (k >= 3) begin
        check("hold_dout", int'(bus.dout), m_last);
        check("hold_no_valid", int'(bus.dout_valid), 0);
      end
    end
    repeat (5) step(1, 0, 0, '0, 0, 0);
    step(1, 1, 0, '0, 0, 0);
    repeat (3) step(1, 0, 0, '0, 0, 0);
    check("sync_clr_phase0", int'(bus.dout), 512);
    repeat (3) step(1, 0, 0, '0, 0, 0);

    // Live retune and waveform switches
    step(1, 1, 1, 32'h0010_0000, 0, 3);
    repeat (5) step(1, 0, 0, '0, 0, 0);
    step(1, 0, 1, 32'h0100_0000, 0, 3);
    repeat (5) step(1, 0, 0, '0, 0, 0);
    step(1, 0, 1, 32'h1000_0000, 300, 2);
    repeat (20) step(1, 0, 0, '0, 0, 0);
    step(1, 0, 1, 32'h0300_0000, 77, 3);
    repeat (6) step(1, 0, 0, '0, 0, 0);

    // Asynchronous reset mid-stream, then confirm shadows came back cleared
    mid_reset();
    repeat (5) step(1, 0, 0, '0, 0, 0);
    repeat (4) step(0, 0, 0, '0, 0, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
